memorystage1: RTL and testbench

- Pipeline stage directly upstream of registersstage2.
- Takes the fetched instruction, drives register-file read indices, and computes effective addresses for LOAD/STORE/ALUM.
- Runs the data-bus handshake and selects the ALU operands.
- Passes the instruction forward to stage 2 with the loaded data. While the bus is busy, or on a register hazard or a taken jump, it inserts NOP bubbles and stalls fetch.

---
 rtl/memorystage1.sv | 174 +++++++++++++++++
 tb/tb_memorystage1.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memorystage1.sv
// Memory stage 1: decodes the fetched instruction, reads the register file, runs the
// data-bus handshake for LOAD/STORE/ALUM and issues instructions (or NOP bubbles) to stage 2.
module memorystage1 #(
   parameter int unsigned BUS_TIMEOUT = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] inbound_instruction,
   input  logic        inbound_valid,
   output logic        stall,
   output logic [3:0]  read_index_a,
   output logic [3:0]  read_index_b,
   input  logic [31:0] read_data_a,
   input  logic [31:0] read_data_b,
   output logic        bus_request,
   output logic        bus_write,
   output logic [1:0]  bus_width,
   output logic [31:0] bus_address,
   output logic [31:0] bus_data_out,
   input  logic [31:0] bus_data_in,
   input  logic        bus_ack,
   output logic        bus_error,
   output logic [31:0] outbound_instruction,
   output logic [31:0] data_out,
   output logic [31:0] alu_operand_a,
   output logic [31:0] alu_operand_b,
   input  logic [3:0]  stage2_write_index,
   input  logic        stage2_writing,
   input  logic        jump
);

   localparam logic [4:0] OPCODE_NOP   = 5'd0;
   localparam logic [4:0] OPCODE_ALU   = 5'd1;
   localparam logic [4:0] OPCODE_ALUMI = 5'd2;
   localparam logic [4:0] OPCODE_ALUM  = 5'd3;
   localparam logic [4:0] OPCODE_LOAD  = 5'd4;
   localparam logic [4:0] OPCODE_STORE = 5'd5;

   localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

   typedef enum logic [1:0] {
      IDLE,
      BUS_WAIT,
      BUBBLE
   } state_t;

   state_t      state;
   logic [31:0] held_instruction;
   logic [31:0] held_a;
   logic [31:0] held_b;
   logic [31:0] timeout_count;

   logic [4:0]  opcode;
   logic [3:0]  index_a;
   logic [3:0]  index_b;
   logic [3:0]  index_d;
   logic [31:0] offset;
   logic [31:0] effective_address;
   logic        is_store;
   logic        is_memory;
   logic        uses_a;
   logic        uses_b;
   logic        hazard;
   logic [31:0] operand_b;
   logic        held_is_alum;
   logic        timed_out;

   always_comb begin
      opcode            = inbound_instruction[31:27];
      index_d           = inbound_instruction[23:20];
      index_a           = inbound_instruction[19:16];
      index_b           = inbound_instruction[15:12];
      offset            = {{16{inbound_instruction[15]}}, inbound_instruction[15:0]};
      effective_address = read_data_a + offset;
      is_store          = (opcode == OPCODE_STORE);
      is_memory         = (opcode == OPCODE_LOAD) || is_store || (opcode == OPCODE_ALUM);
      uses_a            = is_memory || (opcode == OPCODE_ALU) || (opcode == OPCODE_ALUMI);
      // Port B carries D for stores and B for register-register ALU ops; nothing else reads it.
      uses_b            = is_store || (opcode == OPCODE_ALU);
      read_index_a      = index_a;
      read_index_b      = is_store ? index_d : index_b;
      hazard            = inbound_valid && stage2_writing &&
                          ((uses_a && (stage2_write_index == index_a)) ||
                           (uses_b && (stage2_write_index == read_index_b)));
      operand_b         = (opcode == OPCODE_ALUMI) ? offset : read_data_b;
      held_is_alum      = (held_instruction[31:27] == OPCODE_ALUM);
      timed_out         = (BUS_TIMEOUT != 0) && (timeout_count == 32'(BUS_TIMEOUT - 1));
   end

   always_comb begin
      stall = 1'b0;
      case (state)
         IDLE:     stall = !jump && (hazard || (inbound_valid && is_memory));
         BUS_WAIT: stall = !bus_ack;
         BUBBLE:   stall = 1'b1;
         default:  stall = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state                <= IDLE;
         outbound_instruction <= NOP_INSTRUCTION;
         data_out             <= '0;
         alu_operand_a        <= '0;
         alu_operand_b        <= '0;
         bus_address          <= '0;
         bus_data_out         <= '0;
         bus_width            <= '0;
         bus_request          <= 1'b0;
         bus_write            <= 1'b0;
         bus_error            <= 1'b0;
         held_instruction     <= '0;
         held_a               <= '0;
         held_b               <= '0;
         timeout_count        <= '0;
      end else begin
         bus_error <= 1'b0;
         case (state)
            IDLE: begin
               if (jump) begin
                  outbound_instruction <= NOP_INSTRUCTION;
               end else if (hazard) begin
                  outbound_instruction <= NOP_INSTRUCTION;
                  state                <= BUBBLE;
               end else if (inbound_valid && is_memory) begin
                  held_instruction     <= inbound_instruction;
                  held_a               <= read_data_a;
                  held_b               <= read_data_b;
                  bus_address          <= effective_address;
                  bus_write            <= is_store;
                  bus_width            <= inbound_instruction[26:25];
                  bus_data_out         <= read_data_b;
                  bus_request          <= 1'b1;
                  timeout_count        <= '0;
                  outbound_instruction <= NOP_INSTRUCTION;
                  state                <= BUS_WAIT;
               end else if (inbound_valid) begin
                  outbound_instruction <= inbound_instruction;
                  alu_operand_a        <= read_data_a;
                  alu_operand_b        <= operand_b;
               end else begin
                  outbound_instruction <= NOP_INSTRUCTION;
               end
            end
            BUS_WAIT: begin
               // Operands latched at bus start are issued now, with bus data for ALUM.
               if (bus_ack) begin
                  bus_request          <= 1'b0;
                  outbound_instruction <= held_instruction;
                  data_out             <= bus_data_in;
                  alu_operand_a        <= held_a;
                  alu_operand_b        <= held_is_alum ? bus_data_in : held_b;
                  state                <= IDLE;
               end else if (timed_out) begin
                  bus_request          <= 1'b0;
                  bus_error            <= 1'b1;
                  outbound_instruction <= NOP_INSTRUCTION;
                  state                <= IDLE;
               end else begin
                  timeout_count        <= timeout_count + 32'd1;
                  outbound_instruction <= NOP_INSTRUCTION;
               end
            end
            BUBBLE: begin
               outbound_instruction <= NOP_INSTRUCTION;
               state                <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_memorystage1.sv
// Directed bench for memorystage1: hand-computed vectors checked with immediate assertions.
module tb_memorystage1;

   localparam logic [4:0] OP_NOP   = 5'd0;
   localparam logic [4:0] OP_ALU   = 5'd1;
   localparam logic [4:0] OP_ALUMI = 5'd2;
   localparam logic [4:0] OP_LOAD  = 5'd4;
   localparam logic [4:0] OP_STORE = 5'd5;
   localparam logic [31:0] NOP = {OP_NOP, 27'h0};

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] inbound_instruction;
   logic        inbound_valid;
   logic        stall;
   logic [3:0]  read_index_a;
   logic [3:0]  read_index_b;
   logic [31:0] read_data_a;
   logic [31:0] read_data_b;
   logic        bus_request;
   logic        bus_write;
   logic [1:0]  bus_width;
   logic [31:0] bus_address;
   logic [31:0] bus_data_out;
   logic [31:0] bus_data_in;
   logic        bus_ack;
   logic        bus_error;
   logic [31:0] outbound_instruction;
   logic [31:0] data_out;
   logic [31:0] alu_operand_a;
   logic [31:0] alu_operand_b;
   logic [3:0]  stage2_write_index;
   logic        stage2_writing;
   logic        jump;

   logic [31:0] regs [16];
   int          vectors = 0;
   int          miscompares = 0;
   int          stall_cycles;
   int          nop_cycles;
   logic [31:0] instr;

   assign read_data_a = regs[read_index_a];
   assign read_data_b = regs[read_index_b];

   always #5 clock = ~clock;

   memorystage1 #(.BUS_TIMEOUT(4)) dut (
      .clock(clock), .reset(reset),
      .inbound_instruction(inbound_instruction), .inbound_valid(inbound_valid), .stall(stall),
      .read_index_a(read_index_a), .read_index_b(read_index_b),
      .read_data_a(read_data_a), .read_data_b(read_data_b),
      .bus_request(bus_request), .bus_write(bus_write), .bus_width(bus_width),
      .bus_address(bus_address), .bus_data_out(bus_data_out), .bus_data_in(bus_data_in),
      .bus_ack(bus_ack), .bus_error(bus_error),
      .outbound_instruction(outbound_instruction), .data_out(data_out),
      .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b),
      .stage2_write_index(stage2_write_index), .stage2_writing(stage2_writing), .jump(jump)
   );

   function automatic logic [31:0] mk(input logic [4:0] op, input logic [1:0] w,
                                      input logic [3:0] d, input logic [3:0] a,
                                      input logic [15:0] imm);
      return {op, w, 1'b0, d, a, imm};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic step_pre();
      @(negedge clock);
   endtask

   task automatic step_post();
      @(posedge clock);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h0;
      reset = 1'b1;
      inbound_instruction = NOP; inbound_valid = 1'b0;
      bus_data_in = '0; bus_ack = 1'b0;
      stage2_write_index = '0; stage2_writing = 1'b0; jump = 1'b0;
      #12;
      check("reset_outbound", outbound_instruction, NOP);
      check("reset_stall", {31'b0, stall}, 32'd0);
      check("reset_bus_request", {31'b0, bus_request}, 32'd0);
      check("reset_bus_error", {31'b0, bus_error}, 32'd0);
      check("reset_data_out", data_out, 32'h0);
      check("reset_bus_address", bus_address, 32'h0);
      check("reset_alu_b", alu_operand_b, 32'h0);
      step_pre();
      reset = 1'b0;

      // LOAD r4, [r1 - 4]: ack in the third wait cycle
      regs[1] = 32'h0000_1000;
      regs[15] = 32'h0;
      instr = mk(OP_LOAD, 2'd2, 4'd4, 4'd1, 16'hFFFC);
      stall_cycles = 0; nop_cycles = 0;
      for (int i = 0; i < 3; i++) begin
         step_pre();
         inbound_instruction = instr; inbound_valid = 1'b1;
         #1;
         if (stall) stall_cycles++;
         step_post();
         if (outbound_instruction === NOP) nop_cycles++;
      end
      check("load_stall_cycles", stall_cycles, 3);
      check("load_nop_cycles", nop_cycles, 3);
      check("load_index_a", {28'b0, read_index_a}, 32'd1);
      check("load_bus_request", {31'b0, bus_request}, 32'd1);
      check("load_bus_address", bus_address, 32'h0000_0FFC);
      check("load_bus_write", {31'b0, bus_write}, 32'd0);
      check("load_bus_width", {30'b0, bus_width}, 32'd2);
      step_pre();
      bus_ack = 1'b1; bus_data_in = 32'h0000_00AB;
      #1;
      check("load_ack_stall", {31'b0, stall}, 32'd0);
      step_post();
      check("load_outbound", outbound_instruction, instr);
      check("load_data_out", data_out, 32'h0000_00AB);
      check("load_request_drop", {31'b0, bus_request}, 32'd0);

      // STORE r2 -> [r3 + 4], address wraps to 2
      step_pre();
      bus_ack = 1'b0; bus_data_in = '0;
      regs[2] = 32'hDEAD_BEEF; regs[3] = 32'hFFFF_FFFE;
      instr = mk(OP_STORE, 2'd2, 4'd2, 4'd3, 16'h0004);
      inbound_instruction = instr;
      #1;
      check("store_index_b", {28'b0, read_index_b}, 32'd2);
      check("store_stall", {31'b0, stall}, 32'd1);
      step_post();
      check("store_bus_address", bus_address, 32'h0000_0002);
      check("store_bus_write", {31'b0, bus_write}, 32'd1);
      check("store_bus_data", bus_data_out, 32'hDEAD_BEEF);
      step_pre();
      bus_ack = 1'b1;
      #1;
      check("store_ack_stall", {31'b0, stall}, 32'd0);
      step_post();
      check("store_outbound", outbound_instruction, instr);
      check("store_request_drop", {31'b0, bus_request}, 32'd0);

      // ALU r6 = r5 op r7 while stage 2 still writes r5
      step_pre();
      bus_ack = 1'b0;
      regs[5] = 32'h0000_0011; regs[7] = 32'h0000_0022;
      instr = mk(OP_ALU, 2'd0, 4'd6, 4'd5, 16'h7000);
      inbound_instruction = instr;
      stage2_writing = 1'b1; stage2_write_index = 4'd5;
      #1;
      check("hazard_stall", {31'b0, stall}, 32'd1);
      step_post();
      check("hazard_nop", outbound_instruction, NOP);
      step_pre();
      stage2_writing = 1'b0; regs[5] = 32'h0000_00AB;
      #1;
      check("bubble_stall", {31'b0, stall}, 32'd1);
      step_post();
      check("bubble_nop", outbound_instruction, NOP);
      step_pre();
      #1;
      check("hazard_clear_stall", {31'b0, stall}, 32'd0);
      step_post();
      check("hazard_issue", outbound_instruction, instr);
      check("hazard_alu_a", alu_operand_a, 32'h0000_00AB);
      check("hazard_alu_b", alu_operand_b, 32'h0000_0022);

      // ALUMI: stage 2 writing the unused B field must not stall
      step_pre();
      instr = mk(OP_ALUMI, 2'd0, 4'd1, 4'd2, 16'h8001);
      inbound_instruction = instr;
      stage2_writing = 1'b1; stage2_write_index = 4'd8;
      #1;
      check("alumi_stall", {31'b0, stall}, 32'd0);
      step_post();
      check("alumi_outbound", outbound_instruction, instr);
      check("alumi_alu_a", alu_operand_a, 32'hDEAD_BEEF);
      check("alumi_alu_b", alu_operand_b, 32'hFFFF_8001);

      // Jump squashes an inbound LOAD
      step_pre();
      stage2_writing = 1'b0;
      inbound_instruction = mk(OP_LOAD, 2'd2, 4'd4, 4'd1, 16'h0000);
      jump = 1'b1;
      #1;
      check("jump_stall", {31'b0, stall}, 32'd0);
      step_post();
      check("jump_no_request", {31'b0, bus_request}, 32'd0);
      check("jump_outbound", outbound_instruction, NOP);

      // Timeout after 4 unacknowledged request cycles
      step_pre();
      jump = 1'b0;
      step_post();
      check("timeout_request_rise", {31'b0, bus_request}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         step_pre();
         step_post();
         check("timeout_wait_request", {31'b0, bus_request}, 32'd1);
         check("timeout_wait_error", {31'b0, bus_error}, 32'd0);
      end
      step_pre();
      step_post();
      check("timeout_error_pulse", {31'b0, bus_error}, 32'd1);
      check("timeout_request_drop", {31'b0, bus_request}, 32'd0);
      check("timeout_outbound", outbound_instruction, NOP);
      step_pre();
      inbound_valid = 1'b0;
      step_post();
      check("timeout_error_single", {31'b0, bus_error}, 32'd0);
      check("invalid_outbound_nop", outbound_instruction, NOP);

      // Reset mid-wait drops the request without a clock edge
      step_pre();
      inbound_valid = 1'b1;
      step_post();
      check("reset_wait_request", {31'b0, bus_request}, 32'd1);
      #2;
      reset = 1'b1; inbound_valid = 1'b0;
      #1;
      check("async_reset_request", {31'b0, bus_request}, 32'd0);
      check("async_reset_stall", {31'b0, stall}, 32'd0);
      step_pre();
      reset = 1'b0;
      step_post();
      check("post_reset_outbound", outbound_instruction, NOP);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
